// File: rtl/sp_types_pkg.sv
// Shared scratchpad types: bank geometry, bank-controller state and FIFO entry layouts.
package sp_types_pkg;

  localparam int ROW_S_W      = 8;
  localparam int BITS_PER_ROW = 32;
  localparam int SP_TAG_W     = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } spbank_state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_t;

  typedef struct packed {
    logic [ROW_S_W-1:0]      row;
    logic [BITS_PER_ROW-1:0] data;
  } wFIFO_t;

  typedef struct packed {
    logic [ROW_S_W-1:0]  row;
    logic [SP_TAG_W-1:0] tag;
  } rFIFO_t;

endpackage

// File: rtl/sp_bank_arb.sv
// Two-request round-robin arbiter (write vs read); grants only while enabled and
// remembers which class won last so a contended cycle alternates.
module sp_bank_arb
  import sp_types_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic wreq_i,
  input  logic rreq_i,
  output logic wgnt_o,
  output logic rgnt_o
);

  grant_t last_q, last_d;

  always_comb begin
    wgnt_o = 1'b0;
    rgnt_o = 1'b0;
    if (en_i) begin
      if (wreq_i && (!rreq_i || last_q == READ)) begin
        wgnt_o = 1'b1;
      end else if (rreq_i) begin
        rgnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (wgnt_o) begin
      last_d = WRITE;
    end else if (rgnt_o) begin
      last_d = READ;
    end
  end

  // Reset to READ so the first contended grant favours the write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= READ;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sp_bank_ctrl.sv
// Scratchpad bank port controller: drains write/read FIFOs into one single-port
// SRAM bank and returns tagged read rows over a valid/ready response channel.
module sp_bank_ctrl
  import sp_types_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int TAG_W    = SP_TAG_W,
  parameter int ROW_W    = ROW_S_W,
  parameter int DATA_W   = BITS_PER_ROW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wFIFO_empty,
  input  wFIFO_t            wFIFO_rdata,
  output logic              wFIFO_REN,
  input  logic              rFIFO_empty,
  input  rFIFO_t            rFIFO_rdata,
  output logic              rFIFO_REN,
  output logic              sram_en,
  output logic              sram_wen,
  output logic [ROW_W-1:0]  sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  spbank_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic arb_en;
  logic wgnt, rgnt;

  // Gating with RST keeps every strobe low while reset is held, even with FIFOs non-empty.
  assign arb_en = (state_q == IDLE) && !RST;

  sp_bank_arb u_arb (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (arb_en),
    .wreq_i (!wFIFO_empty),
    .rreq_i (!rFIFO_empty),
    .wgnt_o (wgnt),
    .rgnt_o (rgnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tag_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (rgnt) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_INIT;
          tag_d   = rFIFO_rdata.tag;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = sram_rdata;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wFIFO_REN  = wgnt;
    rFIFO_REN  = rgnt;
    sram_en    = wgnt | rgnt;
    sram_wen   = wgnt;
    sram_addr  = '0;
    sram_wdata = '0;
    if (wgnt) begin
      sram_addr  = wFIFO_rdata.row;
      sram_wdata = wFIFO_rdata.data;
    end else if (rgnt) begin
      sram_addr = rFIFO_rdata.row;
    end
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
    rsp_data  = rsp_data_q;
    rsp_tag   = tag_q;
  end

endmodule

// File: tb/tb_sp_bank_ctrl.sv
// Bench for sp_bank_ctrl: a READ_LAT=2 and a READ_LAT=1 instance, each with its own
// FIFOs, SRAM model and transaction-level reference predictor.
module tb_sp_bank_ctrl;
  import sp_types_pkg::*;

  localparam int N = 2;

  logic CLK = 1'b0;
  logic RST;

  logic                    w_empty   [N];
  wFIFO_t                  w_rdata   [N];
  logic                    w_ren     [N];
  logic                    r_empty   [N];
  rFIFO_t                  r_rdata   [N];
  logic                    r_ren     [N];
  logic                    en        [N];
  logic                    wen       [N];
  logic [ROW_S_W-1:0]      addr      [N];
  logic [BITS_PER_ROW-1:0] wdata     [N];
  logic [BITS_PER_ROW-1:0] rdata     [N];
  logic                    rsp_valid [N];
  logic [BITS_PER_ROW-1:0] rsp_data  [N];
  logic [SP_TAG_W-1:0]     rsp_tag   [N];
  logic                    rsp_ready [N];
  logic                    busy      [N];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : 1;

    sp_bank_ctrl #(.READ_LAT(L)) u_dut (
      .CLK         (CLK),
      .RST         (RST),
      .wFIFO_empty (w_empty[g]),
      .wFIFO_rdata (w_rdata[g]),
      .wFIFO_REN   (w_ren[g]),
      .rFIFO_empty (r_empty[g]),
      .rFIFO_rdata (r_rdata[g]),
      .rFIFO_REN   (r_ren[g]),
      .sram_en     (en[g]),
      .sram_wen    (wen[g]),
      .sram_addr   (addr[g]),
      .sram_wdata  (wdata[g]),
      .sram_rdata  (rdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_data    (rsp_data[g]),
      .rsp_tag     (rsp_tag[g]),
      .rsp_ready   (rsp_ready[g]),
      .busy        (busy[g])
    );

    // Behavioural SRAM: read data appears L cycles after the strobe, junk otherwise.
    logic [BITS_PER_ROW-1:0] mem  [2**ROW_S_W];
    logic [BITS_PER_ROW-1:0] pipe [L];

    initial for (int k = 0; k < 2**ROW_S_W; k++) mem[k] = '0;

    always @(posedge CLK) begin
      if (en[g] && wen[g]) mem[addr[g]] <= wdata[g];
      pipe[0] <= (en[g] && !wen[g]) ? mem[addr[g]] : $urandom();
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    assign rdata[g] = pipe[L-1];
  end

  // Reference model state
  wFIFO_t                  wq [N][$];
  rFIFO_t                  rq [N][$];
  logic [BITS_PER_ROW-1:0] emem     [N][2**ROW_S_W];
  bit                      last_r   [N];
  bit                      pend     [N];
  int                      resp_at  [N];
  logic [BITS_PER_ROW-1:0] exp_data [N];
  logic [SP_TAG_W-1:0]     exp_tag  [N];
  bit                      gw [N], gr [N], hs [N];
  int                      cyc;
  bit                      rnd_en;
  bit                      ready_val;

  int n_checks = 0;
  int n_errors = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic wFIFO_t mk_w(input int row, input logic [BITS_PER_ROW-1:0] d);
    wFIFO_t e;
    e.row  = ROW_S_W'(row);
    e.data = d;
    return e;
  endfunction

  function automatic rFIFO_t mk_r(input int row, input int tag);
    rFIFO_t e;
    e.row = ROW_S_W'(row);
    e.tag = SP_TAG_W'(tag);
    return e;
  endfunction

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      w_empty[i] = 1'b0;
      r_empty[i] = 1'b0;
      w_rdata[i] = mk_w(3, $urandom());
      r_rdata[i] = mk_r(3, 1);
    end
    RST = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_en[%0d]", i), en[i], 0);
      chk($sformatf("rst_wren[%0d]", i), w_ren[i], 0);
      chk($sformatf("rst_rren[%0d]", i), r_ren[i], 0);
      chk($sformatf("rst_valid[%0d]", i), rsp_valid[i], 0);
      chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
      chk($sformatf("rst_data[%0d]", i), rsp_data[i], 0);
      chk($sformatf("rst_tag[%0d]", i), rsp_tag[i], 0);
      pend[i]   = 1'b0;
      last_r[i] = 1'b1;
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
  endtask

  task automatic step();
    bit hide_w, hide_r, wv, rv, vexp;
    for (int i = 0; i < N; i++) begin
      hide_w = 1'b0;
      hide_r = 1'b0;
      if (rnd_en) begin
        if (wq[i].size() < 4 && $urandom_range(0, 3) == 0)
          wq[i].push_back(mk_w($urandom_range(0, 15), $urandom()));
        if (rq[i].size() < 4 && $urandom_range(0, 3) == 0)
          rq[i].push_back(mk_r($urandom_range(0, 15), $urandom_range(0, 3)));
        hide_w       = ($urandom_range(0, 3) == 0);
        hide_r       = ($urandom_range(0, 3) == 0);
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end else begin
        rsp_ready[i] = ready_val;
      end
      w_empty[i] = (wq[i].size() == 0) || hide_w;
      r_empty[i] = (rq[i].size() == 0) || hide_r;
      w_rdata[i] = (wq[i].size() != 0) ? wq[i][0] : mk_w($urandom_range(0, 255), $urandom());
      r_rdata[i] = (rq[i].size() != 0) ? rq[i][0] : mk_r($urandom_range(0, 255), $urandom_range(0, 3));
    end
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      wv    = !w_empty[i];
      rv    = !r_empty[i];
      gw[i] = 1'b0;
      gr[i] = 1'b0;
      hs[i] = 1'b0;
      vexp  = pend[i] && (cyc >= resp_at[i]);
      if (!pend[i]) begin
        if (wv && (!rv || last_r[i])) gw[i] = 1'b1;
        else if (rv) gr[i] = 1'b1;
      end else if (vexp && rsp_ready[i]) begin
        hs[i] = 1'b1;
      end
      chk($sformatf("sram_en[%0d]", i), en[i], gw[i] | gr[i]);
      chk($sformatf("sram_wr[%0d]", i), en[i] & wen[i], gw[i]);
      chk($sformatf("wren[%0d]", i), w_ren[i], gw[i]);
      chk($sformatf("rren[%0d]", i), r_ren[i], gr[i]);
      if (gw[i]) begin
        chk($sformatf("waddr[%0d]", i), addr[i], wq[i][0].row);
        chk($sformatf("wdata[%0d]", i), wdata[i], wq[i][0].data);
      end
      if (gr[i]) chk($sformatf("raddr[%0d]", i), addr[i], rq[i][0].row);
      chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], vexp);
      if (vexp) begin
        chk($sformatf("rsp_data[%0d]", i), rsp_data[i], exp_data[i]);
        chk($sformatf("rsp_tag[%0d]", i), rsp_tag[i], exp_tag[i]);
      end
      chk($sformatf("busy[%0d]", i), busy[i], pend[i]);
    end
    @(posedge CLK);
    for (int i = 0; i < N; i++) begin
      if (gw[i]) begin
        emem[i][wq[i][0].row] = wq[i][0].data;
        void'(wq[i].pop_front());
        last_r[i] = 1'b0;
      end
      if (gr[i]) begin
        exp_data[i] = emem[i][rq[i][0].row];
        exp_tag[i]  = rq[i][0].tag;
        void'(rq[i].pop_front());
        pend[i]     = 1'b1;
        resp_at[i]  = cyc + lat_of(i) + 1;
        last_r[i]   = 1'b1;
      end
      if (hs[i]) pend[i] = 1'b0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    RST       = 1'b0;
    cyc       = 0;
    rnd_en    = 1'b0;
    ready_val = 1'b1;
    for (int i = 0; i < N; i++) begin
      rsp_ready[i] = 1'b0;
      w_empty[i]   = 1'b1;
      r_empty[i]   = 1'b1;
      w_rdata[i]   = '0;
      r_rdata[i]   = '0;
      for (int k = 0; k < 2**ROW_S_W; k++) emem[i][k] = '0;
    end
    #2;
    do_reset();

    // Write then read the same row
    for (int i = 0; i < N; i++) begin
      wq[i].push_back(mk_w(5, 32'hA5A5_A5A5));
      rq[i].push_back(mk_r(5, 3));
    end
    repeat (8) step();

    // Both FIFOs pre-loaded from reset: grants alternate starting with the write
    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int k = 1; k <= 3; k++) begin
        wq[i].push_back(mk_w(k, $urandom()));
        rq[i].push_back(mk_r(k, k));
      end
    end
    repeat (20) step();

    // Back-pressured response
    for (int i = 0; i < N; i++) rq[i].push_back(mk_r(2, 1));
    ready_val = 1'b0;
    repeat (10) step();
    ready_val = 1'b1;
    repeat (3) step();

    // Back-to-back writes
    for (int i = 0; i < N; i++)
      for (int k = 4; k <= 7; k++) wq[i].push_back(mk_w(k, $urandom()));
    repeat (6) step();

    // Reset while waiting on SRAM data, then re-read the same row
    for (int i = 0; i < N; i++) rq[i].push_back(mk_r(7, 2));
    step();
    do_reset();
    for (int i = 0; i < N; i++) rq[i].push_back(mk_r(7, 2));
    repeat (8) step();

    // Randomized traffic
    rnd_en = 1'b1;
    repeat (3000) step();
    rnd_en = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
